// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared constants and helpers for the instruction-fetch stage.
//   INSTR_NOP         canonical no-op encoding (addi x0,x0,0)
//   PC_STEP           byte distance between consecutive instructions
//   RESET_PC_DEFAULT  default PC after reset
//   word_idx_w()      number of word-index bits for a memory depth
//   cnt_w()           width of an occupancy counter for a FIFO depth
// ---------------------------------------------------------------------------
package if_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam int unsigned PC_STEP          = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Word index is taken from address bits [word_idx_w+1:2].
    function automatic int unsigned word_idx_w(input int unsigned mem_depth);
        return $clog2(mem_depth);
    endfunction

    // Occupancy counter must be able to represent DEPTH itself.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous clear and show-ahead head output.
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   clear_i  in   empty the FIFO on this edge (wins over push/pop)
//   push_i   in   write data_i at the tail
//   pop_i    in   drop the head entry
//   data_i   in   DATA_W entry to push
//   data_o   out  head entry (meaningful only when empty_o = 0)
//   count_o  out  occupancy, 0..DEPTH
//   empty_o  out  no entries
// ---------------------------------------------------------------------------
module sync_fifo
    import if_pkg::*;
#(
    parameter  int unsigned DATA_W = 64,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves on the
    // same edge; the tail slot then coincides with the departing head.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; entries are only observed once counted.
    always_ff @(posedge clk) begin
        if (!clear_i && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// ---------------------------------------------------------------------------
// if_prefetch
// Instruction-fetch stage: PC register, synchronous instruction memory with a
// program-load port, prefetch FIFO and valid/ready handshake toward decode.
//   CLK          in   clock
//   RST_N        in   asynchronous active-low reset
//   REDIRECT     in   branch/jump taken, restart fetch at REDIRECT_PC
//   REDIRECT_PC  in   redirect target (bits [1:0] ignored)
//   ID_READY     in   decode accepts the head instruction
//   WE/WADDR/WDATA in program-load write port (byte address)
//   VALID        out  head outputs are valid
//   INSTR        out  head instruction
//   INSTR_PC     out  address of head instruction
//   NEXT_PC      out  INSTR_PC + 4
//   COUNT        out  FIFO occupancy
// ---------------------------------------------------------------------------
module if_prefetch
    import if_pkg::*;
#(
    parameter  int unsigned       DATA_W     = 32,
    parameter  int unsigned       ADDR_W     = 32,
    parameter  int unsigned       MEM_DEPTH  = 1024,
    parameter  int unsigned       FIFO_DEPTH = 4,
    parameter  logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
    localparam int unsigned       CNT_W      = cnt_w(FIFO_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    input  logic              ID_READY,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic              VALID,
    output logic [DATA_W-1:0] INSTR,
    output logic [ADDR_W-1:0] INSTR_PC,
    output logic [ADDR_W-1:0] NEXT_PC,
    output logic [CNT_W-1:0]  COUNT
);

    localparam int unsigned IDX_W   = word_idx_w(MEM_DEPTH);
    localparam int unsigned ENTRY_W = DATA_W + ADDR_W;

    // ------------------------------------------------------------------
    // Fetch control
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [ADDR_W-1:0] redirect_pc_aligned;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              pop_req;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_head;
    logic [DATA_W-1:0] head_instr;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] imem [MEM_DEPTH];
    logic              unused_addr_bits;

    assign redirect_pc_aligned = {REDIRECT_PC[ADDR_W-1:2], 2'b00};
    assign fetch_pc            = REDIRECT ? redirect_pc_aligned : pc_q;

    // Occupancy includes the word still in flight so that a slot is
    // reserved for it before the read is issued.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign pop_req   = VALID & ID_READY;
    assign issue     = REDIRECT
                     | (occupancy < (CNT_W + 1)'(FIFO_DEPTH))
                     | pop_req;

    // Redirect kills the in-flight word and suppresses the pop.
    assign fifo_push  = inflight_q & ~REDIRECT;
    assign fifo_pop   = pop_req & ~REDIRECT;
    assign fifo_wdata = {inflight_pc_q, rdata_q};

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (issue) begin
            pc_d          = fetch_pc + ADDR_W'(PC_STEP);
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Instruction memory: registered read, read-old-data on collision.
    // Addresses alias modulo MEM_DEPTH words.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (WE) begin
            imem[WADDR[IDX_W+1:2]] <= WDATA;
        end
        if (issue) begin
            rdata_q <= imem[fetch_pc[IDX_W+1:2]];
        end
    end

    // Address bits outside the word index are intentionally ignored.
    assign unused_addr_bits = ^{WADDR, REDIRECT_PC[1:0]};

    // ------------------------------------------------------------------
    // Prefetch buffer
    // ------------------------------------------------------------------
    sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clear_i (REDIRECT),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (fifo_wdata),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign head_instr = fifo_head[DATA_W-1:0];
    assign head_pc    = fifo_head[ENTRY_W-1:DATA_W];

    // Head outputs read as zero while the buffer is empty, which also gives
    // the all-zero reset view.
    assign VALID    = ~fifo_empty;
    assign INSTR    = VALID ? head_instr : '0;
    assign INSTR_PC = VALID ? head_pc : '0;
    assign NEXT_PC  = VALID ? (head_pc + ADDR_W'(PC_STEP)) : '0;
    assign COUNT    = fifo_count;

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;
    import if_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance
    logic        rst_n, redirect, id_ready, we;
    logic [31:0] redirect_pc, waddr, wdata;
    logic        valid;
    logic [31:0] instr, instr_pc, next_pc;
    logic [2:0]  count;

    // Small instance for wrap/alias
    logic        s_rst_n, s_redirect, s_id_ready, s_we;
    logic [7:0]  s_redirect_pc, s_waddr;
    logic [31:0] s_wdata;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [7:0]  s_instr_pc, s_next_pc;
    logic [2:0]  s_count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_m  [1024];
    logic [31:0] smem_m [16];

    if_prefetch #(
        .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024), .FIFO_DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
        .ID_READY(id_ready), .WE(we), .WADDR(waddr), .WDATA(wdata),
        .VALID(valid), .INSTR(instr), .INSTR_PC(instr_pc), .NEXT_PC(next_pc), .COUNT(count)
    );

    if_prefetch #(
        .DATA_W(32), .ADDR_W(8), .MEM_DEPTH(16), .FIFO_DEPTH(4), .RESET_PC(8'h00)
    ) dut_s (
        .CLK(clk), .RST_N(s_rst_n), .REDIRECT(s_redirect), .REDIRECT_PC(s_redirect_pc),
        .ID_READY(s_id_ready), .WE(s_we), .WADDR(s_waddr), .WDATA(s_wdata),
        .VALID(s_valid), .INSTR(s_instr), .INSTR_PC(s_instr_pc), .NEXT_PC(s_next_pc), .COUNT(s_count)
    );

    // Word index of a byte address in the 1024-word model memory.
    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0; wdata = INSTR_NOP;
        mem_m[widx(a)] = d;
    endtask

    task automatic load_small(input logic [7:0] a, input logic [31:0] d);
        s_we = 1'b1; s_waddr = a; s_wdata = d;
        tick();
        s_we = 1'b0;
        smem_m[int'(a[5:2])] = d;
    endtask

    // Hold reset across one edge, release between edges.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_rst_n = 1'b0;
        redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0; we = 1'b0; waddr = '0; wdata = INSTR_NOP;
        s_redirect = 1'b0; s_redirect_pc = '0; s_id_ready = 1'b0; s_we = 1'b0; s_waddr = '0; s_wdata = '0;
        #2;
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_vec++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        n_vec++; if (next_pc !== 32'h0) begin n_err++; $display("FAIL reset_next_pc: got %h want 0", next_pc); end
        for (int i = 0; i < 8; i++) load_word(32'(i * 4), 32'h1000_0000 + 32'(i));
        for (int i = 8; i < 64; i++) load_word(32'(i * 4), $urandom);
        for (int i = 0; i < 16; i++) load_small(8'(i * 4), $urandom);
        n_vec++; if (valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL reset_hold: got valid=%b count=%0d want 0/0", valid, count); end
        n_vec++; if (s_valid !== 1'b0 || s_count !== 3'd0) begin n_err++; $display("FAIL reset_small: got valid=%b count=%0d want 0/0", s_valid, s_count); end
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        id_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL seq_edge1_valid: got %b want 0", valid); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++;
            if (valid !== 1'b1 || instr !== 32'h1000_0000 + 32'(i) || instr_pc !== 32'(4 * i) || next_pc !== 32'(4 * i + 4)) begin
                n_err++;
                $display("FAIL seq_%0d: got v=%b instr=%h pc=%h npc=%h want 1 %h %h %h", i, valid, instr, instr_pc, next_pc,
                         32'h1000_0000 + 32'(i), 32'(4 * i), 32'(4 * i + 4));
            end
        end
        $display("test_sequential done");
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        int pops;
        id_ready = 1'b0;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_vec++; if (count > 3'd4) begin n_err++; $display("FAIL bp_count_bound: got %0d want <=4", count); end
            if (c >= 2) begin
                n_vec++; if (valid !== 1'b1 || instr !== 32'h1000_0000) begin n_err++; $display("FAIL bp_hold_c%0d: got v=%b instr=%h want 1 10000000", c, valid, instr); end
            end
        end
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL bp_saturate: got %0d want 4", count); end
        id_ready = 1'b1;
        exp_pc = 32'h0;
        pops = 0;
        for (int c = 0; c < 20 && pops < 6; c++) begin
            if (valid) begin
                n_vec++;
                if (instr_pc !== exp_pc || instr !== mem_m[widx(exp_pc)]) begin
                    n_err++;
                    $display("FAIL bp_drain_%0d: got pc=%h instr=%h want %h %h", pops, instr_pc, instr, exp_pc, mem_m[widx(exp_pc)]);
                end
                exp_pc += 4;
                pops++;
            end
            tick();
        end
        n_vec++; if (pops != 6) begin n_err++; $display("FAIL bp_drain_count: got %0d want 6", pops); end
        $display("test_backpressure done");
    endtask

    task automatic test_redirect();
        logic [31:0] exp_pc;
        id_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) tick();
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL redir_setup_count: got %0d want 3", count); end
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        n_vec++; if (valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL redir_flush: got v=%b count=%0d want 0/0", valid, count); end
        tick();
        n_vec++;
        if (valid !== 1'b1 || instr !== mem_m[8] || instr_pc !== 32'h20 || next_pc !== 32'h24) begin
            n_err++;
            $display("FAIL redir_target: got v=%b instr=%h pc=%h npc=%h want 1 %h 20 24", valid, instr, instr_pc, next_pc, mem_m[8]);
        end
        id_ready = 1'b1;
        exp_pc = 32'h20;
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (valid !== 1'b1 || instr_pc !== exp_pc || instr !== mem_m[widx(exp_pc)]) begin
                n_err++;
                $display("FAIL redir_stream_%0d: got v=%b pc=%h instr=%h want 1 %h %h", c, valid, instr_pc, instr, exp_pc, mem_m[widx(exp_pc)]);
            end
            exp_pc += 4;
            tick();
        end
        $display("test_redirect done");
    endtask

    task automatic test_redirect_pop();
        logic [31:0] old_word;
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL rp_pre_valid: got %b want 1", valid); end
        redirect = 1'b1; redirect_pc = 32'h23;
        tick();
        redirect = 1'b0;
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rp_valid_drop: got %b want 0", valid); end
        tick();
        n_vec++;
        if (valid !== 1'b1 || instr_pc !== 32'h20 || instr !== mem_m[8]) begin
            n_err++;
            $display("FAIL rp_unaligned: got v=%b pc=%h instr=%h want 1 20 %h", valid, instr_pc, instr, mem_m[8]);
        end
        // Fetch and write the same word on one edge: fetch sees the old word.
        old_word = mem_m[12];
        redirect = 1'b1; redirect_pc = 32'h30;
        we = 1'b1; waddr = 32'h30; wdata = 32'hDEAD_BEEF;
        tick();
        redirect = 1'b0; we = 1'b0; wdata = INSTR_NOP;
        mem_m[12] = 32'hDEAD_BEEF;
        tick();
        n_vec++; if (instr_pc !== 32'h30 || instr !== old_word) begin n_err++; $display("FAIL rw_collision: got pc=%h instr=%h want 30 %h", instr_pc, instr, old_word); end
        redirect = 1'b1; redirect_pc = 32'h30;
        tick();
        redirect = 1'b0;
        tick();
        n_vec++; if (instr_pc !== 32'h30 || instr !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rw_after: got pc=%h instr=%h want 30 deadbeef", instr_pc, instr); end
        $display("test_redirect_pop done");
    endtask

    task automatic test_wrap_alias();
        s_id_ready = 1'b1;
        s_rst_n = 1'b1;
        s_redirect = 1'b1; s_redirect_pc = 8'hF8;
        tick();
        s_redirect = 1'b0;
        n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL wrap_valid0: got %b want 0", s_valid); end
        tick();
        n_vec++; if (s_valid !== 1'b1 || s_instr_pc !== 8'hF8 || s_instr !== smem_m[14]) begin n_err++; $display("FAIL wrap_f8: got v=%b pc=%h instr=%h want 1 f8 %h", s_valid, s_instr_pc, s_instr, smem_m[14]); end
        tick();
        n_vec++; if (s_instr_pc !== 8'hFC || s_next_pc !== 8'h00 || s_instr !== smem_m[15]) begin n_err++; $display("FAIL wrap_fc: got pc=%h npc=%h instr=%h want fc 00 %h", s_instr_pc, s_next_pc, s_instr, smem_m[15]); end
        tick();
        n_vec++; if (s_instr_pc !== 8'h00 || s_instr !== smem_m[0]) begin n_err++; $display("FAIL wrap_00: got pc=%h instr=%h want 00 %h", s_instr_pc, s_instr, smem_m[0]); end
        s_redirect = 1'b1; s_redirect_pc = 8'h40;
        tick();
        s_redirect = 1'b0;
        tick();
        n_vec++; if (s_valid !== 1'b1 || s_instr_pc !== 8'h40 || s_instr !== smem_m[0] || s_next_pc !== 8'h44) begin n_err++; $display("FAIL alias_40: got v=%b pc=%h instr=%h npc=%h want 1 40 %h 44", s_valid, s_instr_pc, s_instr, s_next_pc, smem_m[0]); end
        $display("test_wrap_alias done");
    endtask

    task automatic test_async_reset();
        id_ready = 1'b1;
        tick();
        tick();
        n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL ar_pre_valid: got %b want 1", valid); end
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++; if (valid !== 1'b0 || count !== 3'd0 || instr !== 32'h0 || instr_pc !== 32'h0) begin n_err++; $display("FAIL ar_immediate: got v=%b count=%0d instr=%h pc=%h want 0 0 0 0", valid, count, instr, instr_pc); end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL ar_edge1: got %b want 0", valid); end
        tick();
        n_vec++; if (valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_m[0]) begin n_err++; $display("FAIL ar_restart: got v=%b pc=%h instr=%h want 1 0 %h", valid, instr_pc, instr, mem_m[0]); end
        $display("test_async_reset done");
    endtask

    // Randomised run: the head must always be the next instruction of the
    // architectural stream (sequential, restarted by each redirect).
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        int          age;
        int          txn;
        exp_pc = 32'h0;
        age = 2;
        txn = 0;
        for (int c = 0; c < 400; c++) begin
            id_ready    = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            tgt         = 32'($urandom_range(0, 255));
            redirect_pc = tgt;
            we          = ($urandom_range(0, 4) == 0);
            waddr       = 32'h800 + 32'(4 * $urandom_range(0, 511)) + 32'($urandom_range(0, 3));
            wdata       = $urandom;
            if (age == 0) begin
                n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rnd_post_redirect_c%0d: got v=%b want 0", c, valid); end
            end else begin
                n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL rnd_throughput_c%0d: got v=%b want 1", c, valid); end
            end
            if (valid) begin
                n_vec++;
                if (instr_pc !== exp_pc || instr !== mem_m[widx(exp_pc)] || next_pc !== exp_pc + 32'd4) begin
                    n_err++;
                    $display("FAIL rnd_head_c%0d: got pc=%h instr=%h npc=%h want %h %h %h", c, instr_pc, instr, next_pc, exp_pc, mem_m[widx(exp_pc)], exp_pc + 32'd4);
                end
            end
            n_vec++; if (count > 3'd4) begin n_err++; $display("FAIL rnd_count_c%0d: got %0d want <=4", c, count); end
            if (redirect) begin
                exp_pc = tgt & 32'hFFFF_FFFC;
                age = 0;
            end else begin
                if (valid && id_ready) begin
                    $display("txn %0d pc=%h instr=%h", txn, instr_pc, instr);
                    txn++;
                    exp_pc += 4;
                end
                if (age < 2) age++;
            end
            if (we) mem_m[widx(waddr)] = wdata;
            tick();
        end
        redirect = 1'b0;
        we = 1'b0;
        load_word(32'h900, 32'hCAFE_0001);
        redirect = 1'b1; redirect_pc = 32'h900;
        tick();
        redirect = 1'b0;
        tick();
        n_vec++; if (valid !== 1'b1 || instr_pc !== 32'h900 || instr !== mem_m[widx(32'h900)]) begin n_err++; $display("FAIL rnd_written_word: got v=%b pc=%h instr=%h want 1 900 %h", valid, instr_pc, instr, mem_m[widx(32'h900)]); end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_wrap_alias();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Parametrised next-generation instruction-fetch stage.
- Owns the PC register and a synchronous instruction memory with a load port. Adds a prefetch FIFO and a valid/ready handshake toward decode.
- A redirect input from the ALU flushes the buffered and in-flight fetches and restarts fetch at the branch target.
- Sits between the control/ALU redirect path and the ID stage. Sustains 1 instruction/cycle when decode is always ready.

Parameters:
- DATA_W, 32, instruction and memory word width.
- ADDR_W, 32, PC width in bytes.
- MEM_DEPTH, 1024, instruction memory words; power of 2.
- FIFO_DEPTH, 4, prefetch buffer entries; power of 2, at least 2.
- RESET_PC, 0, PC value loaded on reset; word aligned.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REDIRECT  in  1  branch/jump taken; PC replaced by REDIRECT_PC.
- REDIRECT_PC  in  ADDR_W  redirect target; bits [1:0] ignored and forced to 0.
- ID_READY  in  1  decode accepts the head instruction this cycle.
- WE  in  1  instruction memory write enable (program load).
- WADDR  in  ADDR_W  byte address of the word to write.
- WDATA  in  DATA_W  word to write.
- VALID  out  1  INSTR, INSTR_PC and NEXT_PC hold a valid FIFO head.
- INSTR  out  DATA_W  head instruction.
- INSTR_PC  out  ADDR_W  address of the head instruction.
- NEXT_PC  out  ADDR_W  INSTR_PC + 4, modulo 2^ADDR_W.
- COUNT  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync-to-edge release):
  - PC = RESET_PC; FIFO empty; COUNT = 0; VALID = 0.
  - In-flight flag = 0; INSTR, INSTR_PC and NEXT_PC = 0.
  - Memory contents are not reset.
- Memory indexing:
  - Word index = address[clog2(MEM_DEPTH)+1:2]; higher bits are ignored, so addresses alias modulo MEM_DEPTH words.
  - Synchronous read with 1-cycle latency.
  - Read and write to the same word on the same edge: the read returns the old data.
- Pipeline:
  - F1: on an edge with issue=1, memory reads word(PC); PC <= PC + 4 (wraps at 2^ADDR_W); the in-flight flag is set with the fetched PC.
  - F2: on the next edge, an in-flight word that has not been killed is pushed into the FIFO.
- Issue rule: issue = (COUNT + inflight < FIFO_DEPTH) OR pop, where pop = VALID AND ID_READY. The FIFO therefore never overflows.
- Latency:
  - First edge after reset release issues RESET_PC.
  - VALID = 1 after the second edge.
- Handshake:
  - Pop occurs on an edge with VALID = 1 and ID_READY = 1.
  - Head outputs are stable while VALID = 1 and ID_READY = 0.
  - Simultaneous push and pop leaves COUNT unchanged.
- Redirect (REDIRECT = 1 at edge k):
  - FIFO cleared; any in-flight word killed (not pushed).
  - Read issued at REDIRECT_PC, ignoring the issue rule; PC <= REDIRECT_PC + 4.
  - Pop is suppressed at edge k.
  - VALID = 0 after edge k; VALID = 1 with the target instruction after edge k+1.
- Redirect has priority over pop and over the in-flight push in the same cycle.
- Back-to-back redirects: each one cancels the previous target fetch.
- Reset asserted mid-operation: immediate return to reset state; pending fetches are lost.
- Writes never stall fetch. A write to an address already buffered in the FIFO does not update that entry (no coherence).

Decomposition:
- Shared package if_pkg: INSTR_NOP constant, PC_STEP = 4, word-index helper function, RESET_PC default.
- One natural sub-module: sync_fifo (parametrised DATA width, DEPTH; push, pop, clear, count). Entry width = DATA_W + ADDR_W (instruction plus its PC).
- The instruction memory stays inline.

Test Plan:
- Sequential fetch:
  - Stimulus: load words 0..7 = 0x1000_0000+i; reset with RESET_PC = 0; ID_READY = 1.
  - Response: VALID rises after the 2nd edge, then INSTR = 0x1000_0000, 0x1000_0001, ... on consecutive cycles with INSTR_PC = 0, 4, 8 and NEXT_PC = 4, 8, 12.
- Backpressure:
  - Stimulus: ID_READY = 0 for 10 cycles, then 1.
  - Response: COUNT saturates at 4; INSTR is held at 0x1000_0000; no instruction is lost or duplicated after release (0x...1 to 0x...5 in order).
- Redirect:
  - Stimulus: REDIRECT = 1 with REDIRECT_PC = 0x20 while COUNT = 3 and a fetch is in flight.
  - Response: VALID = 0 next cycle; then INSTR = word 8, INSTR_PC = 0x20; no stale word appears.
- Redirect plus pop same cycle, and unaligned target 0x23:
  - Response: pop is ignored; the fetch uses 0x20.
- Wrap and alias, with ADDR_W = 8 and MEM_DEPTH = 16:
  - Response: PC 0xFC is followed by 0x00; address 0x40 returns word 0.
- Async reset mid-stream:
  - Stimulus: drop RST_N between edges.
  - Response: VALID and COUNT go to 0 immediately; fetch restarts at RESET_PC.
